// File: rtl/preload_sequencer.sv
// preload_sequencer
//   Upstream control for the mesh compute top. Takes a host weight stream over
//   valid/ready, writes each weight in row-major order to the mesh preload
//   port, then fires one start pulse, waits RUN_CYCLES cycles and signals done.
//
// Ports
//   i_clk, i_rst       clock, synchronous active-high reset
//   i_cmd_valid        begin a job (only looked at while idle)
//   i_s_valid/o_s_ready/i_s_data   weight stream handshake
//   o_preload_valid/o_preload_addr/o_preload_data   mesh preload write port
//   o_start            one-cycle compute start pulse
//   o_busy             high whenever a job is in progress
//   o_done             one-cycle job-complete pulse
module preload_sequencer #(
  parameter int DW         = 8,
  parameter int ROWS       = 1,
  parameter int COLS       = 1,
  parameter int ROW_W      = 1,
  parameter int COL_W      = 2,
  parameter int RUN_CYCLES = 16,
  parameter int CYC_W      = 5
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_cmd_valid,
  input  logic                   i_s_valid,
  output logic                   o_s_ready,
  input  logic [DW-1:0]          i_s_data,
  output logic                   o_preload_valid,
  output logic [ROW_W+COL_W-1:0] o_preload_addr,
  output logic [DW-1:0]          o_preload_data,
  output logic                   o_start,
  output logic                   o_busy,
  output logic                   o_done
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_FLUSH, S_START, S_RUN, S_DONE
  } state_t;

  state_t                   r_state, w_next;
  logic [ROW_W-1:0]         r_row;
  logic [COL_W-1:0]         r_col;
  logic [CYC_W-1:0]         r_cnt;
  logic                     r_pv;
  logic [ROW_W+COL_W-1:0]   r_addr;
  logic [DW-1:0]            r_data;

  logic w_hs, w_last_col, w_last_row, w_run_end;

  // Ready is a pure function of state, so the handshake needs only s_valid.
  assign w_hs       = (r_state == S_LOAD) && i_s_valid;
  assign w_last_col = (r_col == COL_W'(COLS - 1));
  assign w_last_row = (r_row == ROW_W'(ROWS - 1));
  assign w_run_end  = (r_cnt == CYC_W'(RUN_CYCLES - 1));

  always_comb begin
    w_next    = r_state;
    o_s_ready = 1'b0;
    o_start   = 1'b0;
    o_done    = 1'b0;
    o_busy    = (r_state != S_IDLE);
    case (r_state)
      S_IDLE:  if (i_cmd_valid) w_next = S_LOAD;
      S_LOAD: begin
        o_s_ready = 1'b1;
        if (i_s_valid && w_last_row && w_last_col) w_next = S_FLUSH;
      end
      // FLUSH exists so the final preload write lands before start.
      S_FLUSH: w_next = S_START;
      S_START: begin
        o_start = 1'b1;
        w_next  = S_RUN;
      end
      S_RUN:   if (w_run_end) w_next = S_DONE;
      S_DONE: begin
        o_done = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_row   <= '0;
      r_col   <= '0;
      r_cnt   <= '0;
      r_pv    <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
    end else begin
      r_state <= w_next;
      r_pv    <= w_hs;
      if (r_state == S_IDLE && i_cmd_valid) begin
        r_row <= '0;
        r_col <= '0;
      end
      if (w_hs) begin
        r_addr <= {r_row, r_col};
        r_data <= i_s_data;
        if (w_last_col) begin
          r_col <= '0;
          r_row <= r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
      end
      if (r_state == S_START) r_cnt <= '0;
      else if (r_state == S_RUN) r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_preload_valid = r_pv;
  assign o_preload_addr  = r_addr;
  assign o_preload_data  = r_data;

endmodule

// File: tb/tb_preload_sequencer.sv
// Bench for preload_sequencer: two instances (2x3 mesh with RUN_CYCLES=4, and
// the 1x1 default with RUN_CYCLES=16) share one stimulus stream. Each has a
// job-timeline model (handshake index -> row-major address via div/mod, start
// and done cycles computed from the last handshake) checked every cycle, plus
// literal expectations for the directed scenarios.
module tb_preload_sequencer;

  logic       clk = 1'b0;
  logic       rst, cmd, s_valid;
  logic [7:0] s_data;

  logic       s_ready_o [2];
  logic       pv_o      [2];
  logic       start_o   [2];
  logic       busy_o    [2];
  logic       done_o    [2];
  logic [2:0] addr_o    [2];
  logic [7:0] data_o    [2];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Monitor logs for literal checks.
  int wa0[$], wd0[$], wc0[$], wa1[$], wd1[$], wc1[$];
  int st0 = -1, dn0 = -1, ndone0 = 0, st1 = -1, dn1 = -1;

  logic [7:0] wt [6];

  always #5 clk = ~clk;

  task automatic cmp(input string nm, input int g, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d] cyc=%0d got=%0d expected=%0d", nm, g, cyc, act, exp);
    end
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0d expected=%0d", nm, act, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_cfg
    localparam int R  = (g == 0) ? 2 : 1;
    localparam int C  = (g == 0) ? 3 : 1;
    localparam int RC = (g == 0) ? 4 : 16;
    localparam int N  = R * C;

    preload_sequencer #(
      .DW(8), .ROWS(R), .COLS(C), .ROW_W(1), .COL_W(2),
      .RUN_CYCLES(RC), .CYC_W(5)
    ) dut (
      .i_clk(clk), .i_rst(rst), .i_cmd_valid(cmd),
      .i_s_valid(s_valid), .o_s_ready(s_ready_o[g]), .i_s_data(s_data),
      .o_preload_valid(pv_o[g]), .o_preload_addr(addr_o[g]),
      .o_preload_data(data_o[g]), .o_start(start_o[g]),
      .o_busy(busy_o[g]), .o_done(done_o[g])
    );

    // Model: job flag, accepting flag, handshake count, cycle of start/done.
    bit         m_job = 0, m_load = 0, e_pv = 0;
    int         m_k = 0, m_c = 0, m_ts = -1, m_td = -1;
    logic [2:0] e_addr = '0;
    logic [7:0] e_data = '0;
    bit         hs, was_idle;

    always @(posedge clk) begin
      m_c++;
      if (rst) begin
        m_job = 0; m_load = 0; m_k = 0; m_ts = -1; m_td = -1;
        e_pv = 0; e_addr = '0; e_data = '0;
      end else begin
        hs       = m_load && s_valid;
        was_idle = !m_job;
        e_pv     = hs;
        if (hs) begin
          e_addr = 3'(((m_k / C) << 2) | (m_k % C));
          e_data = s_data;
          m_k++;
          if (m_k == N) begin
            m_load = 0;
            m_ts   = m_c + 1;        // handshake cycle + 2
            m_td   = m_ts + RC + 1;
          end
        end
        if (m_job && !m_load && m_c == m_td + 1) m_job = 0;
        if (was_idle && cmd) begin
          m_job = 1; m_load = 1; m_k = 0; m_ts = -1; m_td = -1;
        end
      end
    end

    always @(negedge clk) begin
      if (m_c > 0) begin
        cmp("s_ready", g, int'(s_ready_o[g]), int'(m_load));
        cmp("preload_valid", g, int'(pv_o[g]), int'(e_pv));
        cmp("preload_addr", g, int'(addr_o[g]), int'(e_addr));
        cmp("preload_data", g, int'(data_o[g]), int'(e_data));
        cmp("start", g, int'(start_o[g]), int'(m_job && m_c == m_ts));
        cmp("done", g, int'(done_o[g]), int'(m_job && m_c == m_td));
        cmp("busy", g, int'(busy_o[g]), int'(m_job));
      end
    end
  end

  always @(negedge clk) begin
    cyc++;
    if (pv_o[0]) begin
      wa0.push_back(int'(addr_o[0]));
      wd0.push_back(int'($signed(data_o[0])));
      wc0.push_back(cyc);
    end
    if (start_o[0]) st0 = cyc;
    if (done_o[0]) begin dn0 = cyc; ndone0++; end
    if (pv_o[1]) begin
      wa1.push_back(int'(addr_o[1]));
      wd1.push_back(int'(data_o[1]));
      wc1.push_back(cyc);
    end
    if (start_o[1]) st1 = cyc;
    if (done_o[1]) dn1 = cyc;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    wa0.delete(); wd0.delete(); wc0.delete();
    wa1.delete(); wd1.delete(); wc1.delete();
    st0 = -1; dn0 = -1; ndone0 = 0; st1 = -1; dn1 = -1;
  endtask

  // Push n weights into instance 'which'; mode 1 offers data every 3rd cycle.
  task automatic feed(input int which, input int n, input int mode);
    int i = 0;
    int t = 0;
    bit h;
    while (i < n && t < 300) begin
      s_valid = (mode == 0) ? 1'b1 : (t % 3 == 0);
      s_data  = wt[i % 6];
      @(negedge clk);
      h = s_valid && s_ready_o[which];
      tick();
      if (h) i++;
      t++;
    end
    s_valid = 1'b0;
    chk("feed_count", i, n);
  endtask

  task automatic wait_done(input int which);
    bit got = 0;
    for (int t = 0; t < 200 && !got; t++) begin
      @(negedge clk);
      got = done_o[which];
    end
    tick();
    chk("done_seen", int'(got), 1);
  endtask

  task automatic pulse_cmd();
    cmd = 1'b1;
    tick();
    cmd = 1'b0;
  endtask

  initial begin
    int ea [6] = '{0, 1, 2, 4, 5, 6};
    int ed [6] = '{10, -3, 7, 127, -128, 1};
    wt = '{8'd10, 8'hFD, 8'd7, 8'h7F, 8'h80, 8'd1};
    rst = 1'b1; cmd = 1'b0; s_valid = 1'b1; s_data = 8'h00;

    // Reset and idle with s_valid high and no command.
    repeat (3) tick();
    rst = 1'b0;
    repeat (10) tick();
    chk("idle_writes", wa0.size(), 0);
    chk("idle_start", st0, -1);
    chk("idle_done", dn0, -1);
    s_valid = 1'b0;

    // Back-to-back full job.
    clear_logs();
    pulse_cmd();
    feed(0, 6, 0);
    wait_done(0);
    chk("full_nwrites", wa0.size(), 6);
    if (wa0.size() == 6) begin
      for (int k = 0; k < 6; k++) begin
        chk("full_addr", wa0[k], ea[k]);
        chk("full_data", wd0[k], ed[k]);
      end
      chk("full_consecutive", wc0[5] - wc0[0], 5);
      chk("full_start_after_last", st0 - wc0[5], 1);
    end
    chk("full_done_after_start", dn0 - st0, 5);

    // Bubbled stream.
    clear_logs();
    pulse_cmd();
    feed(0, 6, 1);
    wait_done(0);
    chk("bub_nwrites", wa0.size(), 6);
    if (wa0.size() == 6) begin
      for (int k = 0; k < 6; k++) chk("bub_addr", wa0[k], ea[k]);
      chk("bub_gap_span", wc0[5] - wc0[0], 15);
      chk("bub_start_after_last", int'(st0 > wc0[5]), 1);
    end

    // Command held through LOAD/RUN/DONE and the following IDLE cycle.
    clear_logs();
    cmd = 1'b1;
    tick();
    feed(0, 6, 0);
    wait_done(0);
    chk("ign_one_done", ndone0, 1);
    tick();
    cmd = 1'b0;
    feed(0, 6, 0);
    wait_done(0);
    chk("ign_two_done", ndone0, 2);
    chk("ign_nwrites", wa0.size(), 12);
    if (wa0.size() == 12) chk("ign_job2_addr0", wa0[6], 0);

    // Reset right after the third handshake.
    clear_logs();
    pulse_cmd();
    feed(0, 3, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_pv", int'(pv_o[0]), 0);
    chk("rst_busy", int'(busy_o[0]), 0);
    chk("rst_addr", int'(addr_o[0]), 0);
    chk("rst_data", int'(data_o[0]), 0);
    repeat (30) tick();
    chk("rst_no_start", st0, -1);
    chk("rst_nwrites", wa0.size(), 3);
    clear_logs();
    pulse_cmd();
    feed(0, 6, 0);
    wait_done(0);
    chk("rst_fresh_n", wa0.size(), 6);
    if (wa0.size() > 0) chk("rst_fresh_addr0", wa0[0], 0);

    // Default 1x1 configuration, single weight 0x55.
    repeat (40) tick();
    clear_logs();
    wt[0] = 8'h55;
    pulse_cmd();
    feed(1, 1, 0);
    wait_done(1);
    wt[0] = 8'd10;
    chk("one_nwrites", wa1.size(), 1);
    if (wa1.size() == 1) begin
      chk("one_addr", wa1[0], 0);
      chk("one_data", wd1[0], 8'h55);
      chk("one_start_after", st1 - wc1[0], 1);
    end
    chk("one_done_after_start", dn1 - st1, 17);

    // Random traffic with occasional resets.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      rst     = ($urandom_range(0, 249) == 0);
      cmd     = ($urandom_range(0, 7) == 0);
      s_valid = $urandom_range(0, 1) == 1;
      s_data  = 8'($urandom);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
